div8u_seq: RTL and testbench



---
 rtl/div8u_seq_pkg.sv | 28 ++
 rtl/div8u_seq_div_step.sv | 39 +++
 rtl/div8u_seq.sv | 120 ++++++++++++
 tb/tb_div8u_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/div8u_seq_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential unsigned restoring divider:
//   - state_t    : controller states (IDLE, RUN, DONE)
//   - DW_DEF     : default dividend / quotient width
//   - VW_DEF     : default divisor / remainder width
//   - cnt_width  : width of the step counter for a given dividend width
//   - CW_DEF     : step counter width for the default dividend width
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  // A counter that indexes DW steps needs ceil(log2 DW) bits, never fewer than 1.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CW_DEF = cnt_width(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div8u_seq_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step. The partial remainder is shifted
// left by one with the next dividend bit entering at the bottom; if the
// divisor fits, it is subtracted and the quotient bit is 1, otherwise the
// shifted value is kept and the quotient bit is 0.
//
// Ports:
//   r_i      [VW:0]   current partial remainder
//   q_msb_i           next dividend bit (MSB of the quotient shift register)
//   d_i      [VW-1:0] divisor
//   r_o      [VW:0]   next partial remainder
//   q_bit_o           quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  // One spare bit on top so the compare is exact even before truncation.
  logic [VW+1:0] w_shift;
  logic [VW+1:0] w_diff;
  logic          w_fits;

  assign w_shift = {r_i, q_msb_i};
  assign w_fits  = (w_shift >= {2'b00, d_i});
  assign w_diff  = w_shift - {2'b00, d_i};

  // The remainder before the shift is below the divisor, so the kept value
  // always fits back into VW+1 bits.
  assign r_o     = (VW+1)'(w_fits ? w_diff : w_shift);
  assign q_bit_o = w_fits;

endmodule

// File: rtl/div8u_seq.sv
// -----------------------------------------------------------------------------
// div8u_seq
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Recovers the operands of the 4x4 multiplier family and flags whether the
// quotient fits back into VW bits. Divide-by-zero completes immediately with
// quotient all ones and remainder equal to the low dividend bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid            in_ready   block can accept operands
//   dividend   [DW-1:0] unsigned         divisor    [VW-1:0] unsigned
//   out_valid  result valid              out_ready  consumer accepts result
//   quotient   [DW-1:0]                  remainder  [VW-1:0]
//   fits_vw    quotient < 2^VW and divisor != 0
//   div_zero   divisor was zero
// Result outputs read 0 whenever out_valid is low.
// -----------------------------------------------------------------------------
module div8u_seq
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          fits_vw,
  output logic          div_zero
);

  localparam int CW = cnt_width(DW);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_q;
  logic [VW:0]   r_r;
  logic [VW-1:0] r_d;
  logic [CW-1:0] r_cnt;
  logic          r_div_zero;

  logic [VW:0]   w_r_nxt;
  logic          w_q_bit;
  logic          w_accept;
  logic          w_last_step;
  logic          w_done;

  assign w_accept    = in_valid && (r_state == IDLE);
  assign w_last_step = (r_cnt == CW'(DW - 1));
  assign w_done      = (r_state == DONE);

  div_step #(.VW(VW)) u_step (
    .r_i     (r_r),
    .q_msb_i (r_q[DW-1]),
    .d_i     (r_d),
    .r_o     (w_r_nxt),
    .q_bit_o (w_q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: the next-state value is defaulted before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_state_nxt = (divisor != '0) ? RUN : DONE;
      RUN:     if (w_last_step) w_state_nxt = DONE;
      DONE:    if (out_ready)   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_r        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_d   <= divisor;
      r_cnt <= '0;
      if (divisor == '0) begin
        // Divide-by-zero result is loaded directly; no steps are run.
        r_q        <= '1;
        r_r        <= {1'b0, dividend[VW-1:0]};
        r_div_zero <= 1'b1;
      end else begin
        r_q        <= dividend;
        r_r        <= '0;
        r_div_zero <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_r   <= w_r_nxt;
      r_q   <= {r_q[DW-2:0], w_q_bit};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = w_done;
  assign quotient  = w_done ? r_q : '0;
  assign remainder = w_done ? r_r[VW-1:0] : '0;
  assign fits_vw   = w_done && !r_div_zero && (r_q[DW-1:VW] == '0);
  assign div_zero  = w_done && r_div_zero;

endmodule

// File: tb/tb_div8u_seq.sv
// -----------------------------------------------------------------------------
// tb_div8u_seq
// Directed and randomized checks of div8u_seq against an arithmetic model
// (integer / and %) with the handshake driven at random.
// -----------------------------------------------------------------------------
module tb_div8u_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       fits_vw;
  logic       div_zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div8u_seq #(.DW(8), .VW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .fits_vw   (fits_vw),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_quotient"},  quotient,  0);
    check({tag, "_remainder"}, remainder, 0);
    check({tag, "_fits_vw"},   fits_vw,   0);
    check({tag, "_div_zero"},  div_zero,  0);
  endtask

  // One full transaction: optional idle gap, accept, wait for the result,
  // hold it under backpressure, then drain.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input int hold, input int gap, input bit chk_lat);
    logic [7:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_f;
    int         lat;
    int         wait_n;
    exp_q = (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
    exp_r = (b == 0) ? a[3:0] : 4'(int'(a) % int'(b));
    exp_f = (b != 0) && (exp_q < 8'd16);

    out_ready = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    wait_n   = 0;
    while (!in_ready && wait_n < 50) begin
      step();
      wait_n++;
    end
    check("accept_ready", in_ready, 1);
    step();

    // Garbage on the operand inputs must be ignored while busy.
    in_valid = 1'($urandom_range(0, 1));
    dividend = 8'($urandom);
    divisor  = 4'($urandom);

    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", in_ready, 0);
      step();
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    if (chk_lat) check("latency", lat, (b == 0) ? 0 : 8);
    check("quotient",  quotient,  exp_q);
    check("remainder", remainder, exp_r);
    check("fits_vw",   fits_vw,   exp_f);
    check("div_zero",  div_zero,  (b == 0));

    repeat (hold) begin
      step();
      check("hold_valid",     out_valid, 1);
      check("hold_quotient",  quotient,  exp_q);
      check("hold_remainder", remainder, exp_r);
      check("hold_in_ready",  in_ready,  0);
    end

    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready,  1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    step();
    step();
    check_idle("reset");
    rst = 1'b0;
    step();

    // Directed cases.
    run_op(8'd225, 4'd15, 0, 0, 1'b1);
    run_op(8'd200, 4'd3,  0, 1, 1'b1);
    run_op(8'd7,   4'd9,  0, 0, 1'b1);
    run_op(8'h5A,  4'd0,  0, 2, 1'b1);
    run_op(8'd100, 4'd7,  5, 0, 1'b1);

    // Reset during RUN step 4: the operation is discarded.
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 4'd7;
    step();
    in_valid = 1'b0;
    check("mid_busy", in_ready, 0);
    repeat (3) step();
    rst      = 1'b1;
    in_valid = 1'b1;
    step();
    check_idle("rst_mid");

    // Reset together with in_valid while idle: operand must not be taken.
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check("rst_no_accept", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("rst_no_result", out_valid, 0);
      step();
    end
    out_ready = 1'b0;

    // Exact-inverse sweep against the multiplier: (a*b)/b == a.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(8'(a * b), 4'(b), $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
      end
    end

    // Random operands, divisor zero included.
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 2),
             $urandom_range(0, 1), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
